// File: rtl/costas_clk_pkg.sv
// Shared types and constants for the Costas clocking path: counter width,
// strobe/window configuration record and its validity rule.
package costas_clk_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t div;
    cnt_t open;
    cnt_t close;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{div: cnt_t'(15), open: cnt_t'(1), close: cnt_t'(13)};

  // A config is usable only if the counter can never run past div-1 and the
  // unlock window is non-empty and lies inside the period.
  function automatic logic cfg_valid(input cfg_t c);
    return (c.div >= cnt_t'(2)) && (c.open < c.close) && (c.close <= c.div - cnt_t'(1));
  endfunction

endpackage

// File: rtl/strobe_cfg_shadow.sv
// Shadow/active config registers: validates writes, flags rejects, and swaps
// the shadow into the active set only at safe points (wrap, resync, disabled).
module strobe_cfg_shadow
  import costas_clk_pkg::*;
#(
  parameter cfg_t RST_CFG = CFG_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic resync,
  input  logic wrap,
  input  logic cfg_wr,
  input  cfg_t cfg_in,
  output cfg_t active,
  output logic cfg_pending,
  output logic cfg_err
);

  cfg_t shadow_q;
  cfg_t shadow_d;
  cfg_t active_d;
  logic pending_d;
  logic err_d;
  logic wr_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ok     = cfg_wr && cfg_valid(cfg_in);
    err_d     = cfg_wr && !wr_ok;
    shadow_d  = shadow_q;
    active_d  = active;
    pending_d = cfg_pending;

    if (resync && wr_ok) begin
      // Resync restarts the period anyway, so a write riding on it goes live at once.
      active_d  = cfg_in;
      shadow_d  = cfg_in;
      pending_d = 1'b0;
    end else begin
      if (resync || wrap || !enable) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (wr_ok) begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge), so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_q    <= RST_CFG;
      active      <= RST_CFG;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active      <= active_d;
      cfg_pending <= pending_d;
      cfg_err     <= err_d;
    end
  end

endmodule

// File: rtl/strobe_window_gen.sv
// Programmable clock divider: one-cycle strobe at count 0 and an unlock window
// over open < count <= close, with enable, resync and boundary-safe reconfig.
module strobe_window_gen
  import costas_clk_pkg::*;
#(
  parameter int CNT_W         = costas_clk_pkg::CNT_W,
  parameter int DIV_DEFAULT   = 15,
  parameter int OPEN_DEFAULT  = 1,
  parameter int CLOSE_DEFAULT = 13
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             resync,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_open,
  input  logic [CNT_W-1:0] cfg_close,
  output logic             strobe,
  output logic             unlock,
  output logic [CNT_W-1:0] phase,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam cfg_t RST_CFG = '{
    div:   cnt_t'(DIV_DEFAULT),
    open:  cnt_t'(OPEN_DEFAULT),
    close: cnt_t'(CLOSE_DEFAULT)
  };

  cfg_t act;
  cfg_t cfg_in;
  cnt_t count_q;
  cnt_t count_nxt;
  logic wrap;
  logic strobe_d;
  logic unlock_d;

  assign cfg_in = '{div: cnt_t'(cfg_div), open: cnt_t'(cfg_open), close: cnt_t'(cfg_close)};

  strobe_cfg_shadow #(
    .RST_CFG (RST_CFG)
  ) u_shadow (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .resync      (resync),
    .wrap        (wrap),
    .cfg_wr      (cfg_wr),
    .cfg_in      (cfg_in),
    .active      (act),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  always_comb begin
    wrap      = 1'b0;
    count_nxt = count_q;
    if (resync) begin
      count_nxt = '0;
    end else if (enable) begin
      // >= rather than == so a count held above a newly activated div still wraps.
      if (count_q >= act.div - cnt_t'(1)) begin
        count_nxt = '0;
        wrap      = 1'b1;
      end else begin
        count_nxt = count_q + cnt_t'(1);
      end
    end
  end

  // A wrap or resync lands on count 0, where unlock is 0 under any config,
  // so evaluating against the current active set is exact.
  assign strobe_d = enable && (count_nxt == '0);
  assign unlock_d = enable && (count_nxt > act.open) && (count_nxt <= act.close);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      strobe  <= 1'b0;
      unlock  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      strobe  <= strobe_d;
      unlock  <= unlock_d;
    end
  end

  assign phase = CNT_W'(count_q);

endmodule

// File: tb/tb_strobe_window_gen.sv
// Self-checking bench for strobe_window_gen: directed scenarios plus random
// traffic, every cycle compared against a behavioural period/window model.
module tb_strobe_window_gen;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n, enable, resync, cfg_wr;
  logic [W-1:0] cfg_div, cfg_open, cfg_close;
  logic         strobe, unlock, cfg_pending, cfg_err;
  logic [W-1:0] phase;

  int errors = 0;
  int checks = 0;

  // Reference state: current count, active and shadow config, registered flags.
  int m_count, a_div, a_open, a_close, s_div, s_open, s_close;
  bit m_strobe, m_unlock, m_pend, m_err;

  always #5 clock = ~clock;

  strobe_window_gen #(
    .CNT_W(W), .DIV_DEFAULT(15), .OPEN_DEFAULT(1), .CLOSE_DEFAULT(13)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .resync      (resync),
    .cfg_wr      (cfg_wr),
    .cfg_div     (cfg_div),
    .cfg_open    (cfg_open),
    .cfg_close   (cfg_close),
    .strobe      (strobe),
    .unlock      (unlock),
    .phase       (phase),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit wrapped, ok;
    int nxt, d, o, c;
    if (!reset_n) begin
      m_count = 0; m_strobe = 0; m_unlock = 0; m_pend = 0; m_err = 0;
      a_div = 15; a_open = 1; a_close = 13;
      s_div = 15; s_open = 1; s_close = 13;
      return;
    end
    d = int'(cfg_div); o = int'(cfg_open); c = int'(cfg_close);
    wrapped = 0;
    nxt = m_count;
    if (resync) nxt = 0;
    else if (enable) begin
      if (m_count + 1 >= a_div) begin nxt = 0; wrapped = 1; end
      else nxt = m_count + 1;
    end
    ok = cfg_wr && d >= 2 && o < c && c < d;
    m_err = cfg_wr && !ok;
    if (resync && ok) begin
      a_div = d; a_open = o; a_close = c;
      s_div = d; s_open = o; s_close = c;
      m_pend = 0;
    end else begin
      if (resync || wrapped || !enable) begin
        a_div = s_div; a_open = s_open; a_close = s_close;
        m_pend = 0;
      end
      if (ok) begin
        s_div = d; s_open = o; s_close = c;
        m_pend = 1;
      end
    end
    m_count  = nxt;
    m_strobe = enable && nxt == 0;
    m_unlock = enable && nxt > a_open && nxt <= a_close;
  endtask

  task automatic cycle(input bit rn, input bit en, input bit rs, input bit wr,
                       input int d = 0, input int o = 0, input int c = 0);
    @(negedge clock);
    reset_n = rn; enable = en; resync = rs; cfg_wr = wr;
    cfg_div = d[W-1:0]; cfg_open = o[W-1:0]; cfg_close = c[W-1:0];
    @(posedge clock);
    model_edge();
    #1;
    check("strobe", strobe, m_strobe);
    check("unlock", unlock, m_unlock);
    check("phase", phase, m_count);
    check("cfg_pending", cfg_pending, m_pend);
    check("cfg_err", cfg_err, m_err);
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < 300 && int'(phase) != p; i++) cycle(1, 1, 0, 0);
    check("reach_phase", phase, p);
  endtask

  // Cycles until the next strobe, bounded.
  task automatic period_len(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      cycle(1, 1, 0, 0);
      if (strobe) begin n = i; break; end
    end
  endtask

  initial begin
    int n, first;
    reset_n = 0; enable = 0; resync = 0; cfg_wr = 0;
    cfg_div = '0; cfg_open = '0; cfg_close = '0;

    // Reset state.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 1, 8, 2, 5);
    check("rst_phase", phase, 0);
    check("rst_strobe", strobe, 0);

    // Defaults: first strobe 15 cycles after release, then every 15.
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1, 1, 0, 0);
      if (strobe && first == 0) first = i;
    end
    check("first_strobe", first, 15);

    // Deferred config: current 15-cycle period completes, next is 8.
    run_to_phase(6);
    cycle(1, 1, 0, 1, 8, 2, 5);
    check("pend_set", cfg_pending, 1);
    period_len(n);
    check("old_period_tail", n, 8);
    check("pend_clear", cfg_pending, 0);
    period_len(n);
    check("new_period", n, 8);

    // Rejected writes back under defaults.
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 1, 8, 5, 5);
    check("err_equal", cfg_err, 1);
    cycle(1, 1, 0, 1, 4, 1, 4);
    check("err_close", cfg_err, 1);
    cycle(1, 1, 0, 0);
    check("err_pulse", cfg_err, 0);
    period_len(n);
    period_len(n);
    check("period_kept", n, 15);

    // Resync, then resync with an immediate config.
    run_to_phase(9);
    cycle(1, 1, 1, 0);
    check("resync_phase", phase, 0);
    check("resync_strobe", strobe, 1);
    period_len(n);
    check("resync_period", n, 15);
    cycle(1, 1, 1, 1, 6, 0, 3);
    check("rs_cfg_pend", cfg_pending, 0);
    period_len(n);
    check("rs_cfg_period", n, 6);

    // Freeze at phase 4.
    run_to_phase(4);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0);
      check("hold_phase", phase, 4);
    end
    cycle(1, 1, 0, 0);
    check("resume_phase", phase, 5);

    // Reset mid-period with a config pending.
    cycle(0, 1, 0, 0);
    run_to_phase(3);
    cycle(1, 1, 0, 1, 8, 2, 5);
    run_to_phase(11);
    cycle(0, 1, 0, 0);
    check("rst_mid_pend", cfg_pending, 0);
    check("rst_mid_phase", phase, 0);
    period_len(n);
    check("rst_mid_period", n, 15);
    period_len(n);
    check("rst_pend_lost", n, 15);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 11) == 0),
            int'($urandom_range(0, 20)),
            int'($urandom_range(0, 20)),
            int'($urandom_range(0, 20)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
